// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipeline_stall_ctrl_pkg;

  // MEM-stage SRAM access sequencer states.
  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Register index of the program counter in the ARM register file.
  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Combinational RAW hazard detection between ID sources and EX/MEM destinations.
// With forwarding enabled only a load in EX (load-use) needs a stall.
module hazard_detect
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic       fwd_en,
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic       uses_src1,
  input  logic       two_src,
  input  logic [3:0] ex_dest,
  input  logic       ex_wb_en,
  input  logic       ex_mem_read,
  input  logic [3:0] mem_dest,
  input  logic       mem_wb_en,
  output logic       hazard
);

  logic m1;
  logic m2;
  logic load_use;

  // Source/destination matches and the forwarding-dependent hazard select.
  always_comb begin
    m1 = uses_src1 & ((ex_wb_en & (src1 == ex_dest)) | (mem_wb_en & (src1 == mem_dest)));
    m2 = two_src   & ((ex_wb_en & (src2 == ex_dest)) | (mem_wb_en & (src2 == mem_dest)));
    load_use = ex_mem_read & ex_wb_en &
               ((uses_src1 & (src1 == ex_dest)) | (two_src & (src2 == ex_dest)));
    hazard = fwd_en ? load_use : (m1 | m2);
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// State table:
//   IDLE     | no SRAM access outstanding; a memReq launches one
//   MEM_WAIT | SRAM access in flight; waiting for sramReady or timeout
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwdEn,
  input  logic [3:0]       idSrc1,
  input  logic [3:0]       idSrc2,
  input  logic             idUsesSrc1,
  input  logic             idTwoSrc,
  input  logic [3:0]       exDest,
  input  logic             exWbEn,
  input  logic             exMemRead,
  input  logic [3:0]       memDest,
  input  logic             memWbEn,
  input  logic             memReq,
  input  logic             branchTaken,
  input  logic             sramReady,
  output logic             sramStart,
  output logic             freezeFront,
  output logic             idExClear,
  output logic             ifIdFlush,
  output logic             freezeBack,
  output logic             memError,
  output logic [CNT_W-1:0] stallCount
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       hazard;
  logic       mem_stall;
  logic       timeout;
  logic       freeze_front_raw;

  hazard_detect u_hazard (
    .fwd_en      (fwdEn),
    .src1        (idSrc1),
    .src2        (idSrc2),
    .uses_src1   (idUsesSrc1),
    .two_src     (idTwoSrc),
    .ex_dest     (exDest),
    .ex_wb_en    (exWbEn),
    .ex_mem_read (exMemRead),
    .mem_dest    (memDest),
    .mem_wb_en   (memWbEn),
    .hazard      (hazard)
  );

  // Memory stall and timeout detection from the current sequencer state.
  always_comb begin
    mem_stall = (state == IDLE) ? memReq : ~sramReady;
    timeout   = (state == MEM_WAIT) & ~sramReady & (wait_cnt == WAIT_LAST);
  end

  // Output priority memStall > branchTaken > hazard; everything held low during reset.
  always_comb begin
    freeze_front_raw = mem_stall | (hazard & ~branchTaken);
    sramStart        = rst & (state == IDLE) & memReq;
    freezeBack       = rst & mem_stall;
    freezeFront      = rst & freeze_front_raw;
    ifIdFlush        = rst & branchTaken & ~mem_stall;
    idExClear        = rst & (branchTaken | hazard) & ~mem_stall;
  end

  // SRAM access sequencer with wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      memError <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memReq) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (sramReady) begin
            state <= IDLE;
          end else if (timeout) begin
            memError <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of front-end freeze cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCount <= '0;
    end else if (freeze_front_raw && (stallCount != {CNT_W{1'b1}})) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fwdEn, idUsesSrc1, idTwoSrc, exWbEn, exMemRead, memWbEn;
  logic        memReq, branchTaken, sramReady;
  logic [3:0]  idSrc1, idSrc2, exDest, memDest;
  logic        sramStart, freezeFront, idExClear, ifIdFlush, freezeBack, memError;
  logic [15:0] stallCount;
  logic        s_sramStart, s_freezeFront, s_idExClear, s_ifIdFlush, s_freezeBack, s_memError;
  logic [2:0]  s_stallCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.WAIT_MAX(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fwdEn(fwdEn), .idSrc1(idSrc1), .idSrc2(idSrc2),
    .idUsesSrc1(idUsesSrc1), .idTwoSrc(idTwoSrc), .exDest(exDest), .exWbEn(exWbEn),
    .exMemRead(exMemRead), .memDest(memDest), .memWbEn(memWbEn), .memReq(memReq),
    .branchTaken(branchTaken), .sramReady(sramReady), .sramStart(sramStart),
    .freezeFront(freezeFront), .idExClear(idExClear), .ifIdFlush(ifIdFlush),
    .freezeBack(freezeBack), .memError(memError), .stallCount(stallCount)
  );

  // Narrow-counter copy, used only to observe saturation.
  pipeline_stall_ctrl #(.WAIT_MAX(15), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .fwdEn(fwdEn), .idSrc1(idSrc1), .idSrc2(idSrc2),
    .idUsesSrc1(idUsesSrc1), .idTwoSrc(idTwoSrc), .exDest(exDest), .exWbEn(exWbEn),
    .exMemRead(exMemRead), .memDest(memDest), .memWbEn(memWbEn), .memReq(memReq),
    .branchTaken(branchTaken), .sramReady(sramReady), .sramStart(s_sramStart),
    .freezeFront(s_freezeFront), .idExClear(s_idExClear), .ifIdFlush(s_ifIdFlush),
    .freezeBack(s_freezeBack), .memError(s_memError), .stallCount(s_stallCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    fwdEn = 0; idUsesSrc1 = 0; idTwoSrc = 0; exWbEn = 0; exMemRead = 0; memWbEn = 0;
    memReq = 0; branchTaken = 0; sramReady = 0;
    idSrc1 = 0; idSrc2 = 0; exDest = 0; memDest = 0;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    memReq = 1;
    #3;
    // Outputs forced low while in reset.
    chk("rst_sramStart", sramStart, 0);
    chk("rst_freezeBack", freezeBack, 0);
    chk("rst_freezeFront", freezeFront, 0);
    chk("rst_stallCount", stallCount, 0);
    memReq = 0;
    @(negedge clk);
    rst = 1'b1;

    // 1. Reset in the middle of an access.
    step();
    memReq = 1;
    #1;
    chk("t1_sramStart", sramStart, 1);
    step();
    memReq = 0;
    #1;
    chk("t1_wait_freezeBack", freezeBack, 1);
    chk("t1_wait_sramStart", sramStart, 0);
    chk("t1_wait_stallCount", stallCount, 1);
    rst = 1'b0;
    #1;
    chk("t1_async_freezeBack", freezeBack, 0);
    chk("t1_async_freezeFront", freezeFront, 0);
    chk("t1_async_stallCount", stallCount, 0);
    chk("t1_async_memError", memError, 0);
    rst = 1'b1;
    #1;
    chk("t1_idle_freezeBack", freezeBack, 0);

    // 3. RAW hazards without forwarding.
    step();
    fwdEn = 0; exDest = 3; exWbEn = 1; idSrc1 = 3; idUsesSrc1 = 1;
    #1;
    chk("t3_ex_freezeFront", freezeFront, 1);
    chk("t3_ex_idExClear", idExClear, 1);
    chk("t3_ex_freezeBack", freezeBack, 0);
    chk("t3_ex_ifIdFlush", ifIdFlush, 0);
    idUsesSrc1 = 0;
    #1;
    chk("t3_nouse_freezeFront", freezeFront, 0);
    chk("t3_nouse_idExClear", idExClear, 0);
    memDest = 7; memWbEn = 1; idSrc2 = 7; idTwoSrc = 1;
    #1;
    chk("t3_mem_freezeFront", freezeFront, 1);
    idTwoSrc = 0;
    #1;
    chk("t3_mem_nosrc2", freezeFront, 0);
    idTwoSrc = 1; fwdEn = 1;
    #1;
    chk("t3_mem_fwd", freezeFront, 0);

    // 4. Load-use with forwarding.
    step();
    clear_inputs();
    fwdEn = 1; exMemRead = 1; exWbEn = 1; exDest = 5; idTwoSrc = 1; idSrc2 = 5;
    #1;
    chk("t4_lu_freezeFront", freezeFront, 1);
    chk("t4_lu_idExClear", idExClear, 1);
    exMemRead = 0;
    #1;
    chk("t4_nolu_freezeFront", freezeFront, 0);
    chk("t4_nolu_idExClear", idExClear, 0);

    // 5. Branch versus hazard versus memory stall.
    step();
    clear_inputs();
    exDest = 3; exWbEn = 1; idSrc1 = 3; idUsesSrc1 = 1; branchTaken = 1;
    #1;
    chk("t5_br_ifIdFlush", ifIdFlush, 1);
    chk("t5_br_idExClear", idExClear, 1);
    chk("t5_br_freezeFront", freezeFront, 0);
    chk("t5_br_freezeBack", freezeBack, 0);
    memReq = 1;
    #1;
    chk("t5_mem_freezeFront", freezeFront, 1);
    chk("t5_mem_freezeBack", freezeBack, 1);
    chk("t5_mem_ifIdFlush", ifIdFlush, 0);
    chk("t5_mem_idExClear", idExClear, 0);
    memReq = 0;
    #1;
    clear_inputs();

    // 2. SRAM read with forwarding, ready after five stalled cycles.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    step();
    fwdEn = 1; memReq = 1;
    #1;
    chk("t2_sramStart", sramStart, 1);
    chk("t2_freezeBack", freezeBack, 1);
    chk("t2_freezeFront", freezeFront, 1);
    step();
    memReq = 0;
    #1;
    chk("t2_pulse_end", sramStart, 0);
    chk("t2_wait_freezeBack", freezeBack, 1);
    chk("t2_wait_stallCount", stallCount, 1);
    for (int i = 0; i < 4; i++) step();
    sramReady = 1;
    #1;
    chk("t2_rdy_freezeBack", freezeBack, 0);
    chk("t2_rdy_freezeFront", freezeFront, 0);
    chk("t2_rdy_stallCount", stallCount, 5);
    chk("t2_small_stallCount", s_stallCount, 5);
    step();
    sramReady = 0;
    #1;
    chk("t2_done_stallCount", stallCount, 5);
    chk("t2_done_freezeBack", freezeBack, 0);
    chk("t2_done_memError", memError, 0);

    // 6. Timeout after 15 MEM_WAIT cycles.
    memReq = 1;
    step();
    memReq = 0;
    for (int i = 0; i < 14; i++) step();
    #1;
    chk("t6_last_wait_memError", memError, 0);
    chk("t6_last_wait_freezeBack", freezeBack, 1);
    step();
    #1;
    chk("t6_memError", memError, 1);
    chk("t6_freezeBack", freezeBack, 0);
    chk("t6_sramStart", sramStart, 0);
    chk("t6_stallCount", stallCount, 21);
    chk("t6_small_saturated", s_stallCount, 7);
    step();
    step();
    #1;
    chk("t6_sticky_memError", memError, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_memError", memError, 0);
    chk("t6_rst_stallCount", stallCount, 0);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
